// File: rtl/apb_master.sv
// apb_master: single-command APB requester for two 8-bit memory slaves, slave picked by req_addr[8].
// Completion is either the selected slave's pready or a TIMEOUT-cycle abort of the ACCESS phase.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       transfer,
    input  logic       req_write,
    input  logic [8:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       psel1,
    output logic       psel2,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic       pready1,
    input  logic       pready2,
    input  logic [7:0] prdata1,
    input  logic [7:0] prdata2
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_nx;
    logic          live;
    logic          sel;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          ready_sel;
    logic [7:0]    rdata_sel;
    logic          done_ok;
    logic          done_to;

    // live keeps req_ready low until the first edge after reset release
    assign req_ready = live && state == IDLE;
    assign accept    = req_ready && transfer;
    assign ready_sel = sel ? pready2 : pready1;
    assign rdata_sel = sel ? prdata2 : prdata1;
    assign psel1     = state != IDLE && !sel;
    assign psel2     = state != IDLE && sel;
    assign penable   = state == ACCESS;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state)
            IDLE:    state_nx = accept ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS: begin
                done_ok  = ready_sel;
                done_to  = !ready_sel && cnt == LAST;
                state_nx = (done_ok || done_to) ? IDLE : ACCESS;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            live      <= 1'b0;
            sel       <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            live      <= 1'b1;
            rsp_valid <= done_ok || done_to;
            cnt       <= state == ACCESS ? cnt + 1'b1 : '0;
            if (accept) begin
                sel    <= req_addr[8];
                paddr  <= req_addr[7:0];
                pwrite <= req_write;
                pwdata <= req_wdata;
            end
            if (done_ok || done_to) begin
                rsp_rdata <= (done_ok && !pwrite) ? rdata_sel : 8'h00;
                rsp_err   <= done_to;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: random and directed APB transfers against two registered-ready memory slaves,
// checked against a memory-image reference model and the expected transfer latency.
module tb_apb_master;
    localparam int TO = 4;

    logic       pclk, preset, transfer, req_write;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel1, psel2, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready1, pready2;
    logic [7:0] prdata1, prdata2;
    logic       stall1, stall2;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0] mem     [2][256];
    logic [7:0] ref_mem [2][256];

    apb_master #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .transfer(transfer), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready1(pready1), .pready2(pready2),
        .prdata1(prdata1), .prdata2(prdata2)
    );

    initial begin
        pclk = 0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic [7:0] seed(int s, int a);
        return 8'((a * 3) ^ (s != 0 ? 8'hA5 : 8'h5A));
    endfunction

    // slaves: pready registered one cycle after they see ACCESS
    always @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int i = 0; i < 256; i++) begin
                mem[0][i] <= seed(0, i);
                mem[1][i] <= seed(1, i);
            end
            pready1 <= 1'b0;
            pready2 <= 1'b0;
        end else begin
            pready1 <= psel1 && penable && !stall1;
            pready2 <= psel2 && penable && !stall2;
            if (psel1 && penable && pready1 && pwrite) mem[0][paddr] <= pwdata;
            if (psel2 && penable && pready2 && pwrite) mem[1][paddr] <= pwdata;
        end
    end

    assign prdata1 = mem[0][paddr];
    assign prdata2 = mem[1][paddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = seed(0, i);
            ref_mem[1][i] = seed(1, i);
        end
    endtask

    task automatic bus_zero(input string tag);
        check({tag, "_psel1"}, psel1, 0);
        check({tag, "_psel2"}, psel2, 0);
        check({tag, "_penable"}, penable, 0);
        check({tag, "_pwrite"}, pwrite, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // one transfer; inputs are scrambled after accept to show the bus ignores them
    task automatic xfer(input logic w, input logic [8:0] a, input logic [7:0] d, input logic stall);
        int lat, en, guard;
        int s;
        logic [7:0] exp_d;
        s = int'(a[8]);
        stall1 = stall && s == 0;
        stall2 = stall && s == 1;
        transfer = 1; req_write = w; req_addr = a; req_wdata = d;
        guard = 0;
        @(negedge pclk);
        while (!req_ready && guard < 20) begin
            guard++;
            @(negedge pclk);
        end
        check("accept_ready", req_ready, 1);
        @(posedge pclk);
        #1;
        transfer = 0; req_addr = 9'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
        lat = 0; en = 0;
        @(negedge pclk);
        while (!rsp_valid && lat < TO + 10) begin
            check("busy_psel1", psel1, s == 0);
            check("busy_psel2", psel2, s == 1);
            check("busy_paddr", paddr, a[7:0]);
            check("busy_pwrite", pwrite, w);
            check("busy_pwdata", pwdata, d);
            check("busy_req_ready", req_ready, 0);
            en += int'(penable);
            @(negedge pclk);
            lat++;
        end
        exp_d = (stall || w) ? 8'h00 : ref_mem[s][a[7:0]];
        if (!stall && w) ref_mem[s][a[7:0]] = d;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_latency", lat, stall ? TO + 1 : 3);
        check("access_cycles", en, stall ? TO : 2);
        check("rsp_err", rsp_err, stall);
        check("rsp_rdata", rsp_rdata, exp_d);
        check("rsp_req_ready", req_ready, 1);
        check("rsp_psel", {psel1, psel2, penable}, 0);
        @(negedge pclk);
        check("rsp_pulse", rsp_valid, 0);
        check("rsp_hold", {rsp_err, rsp_rdata}, {stall, exp_d});
        stall1 = 0; stall2 = 0;
    endtask

    initial begin
        int acc[3];
        int k, guard;
        logic setup_chk;
        preset = 0; transfer = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        stall1 = 0; stall2 = 0;
        ref_reset();
        repeat (2) @(negedge pclk);
        bus_zero("reset");
        preset = 1;
        @(negedge pclk);
        check("ready_after_reset", req_ready, 1);

        xfer(1, 9'h1A5, 8'h3C, 0);
        xfer(0, 9'h1A5, 8'h00, 0);
        check("readback_1a5", ref_mem[1][8'hA5], 8'h3C);
        xfer(1, 9'h010, 8'h77, 0);
        xfer(0, 9'h010, 8'h00, 0);
        xfer(0, 9'h110, 8'h00, 0);
        xfer(0, 9'h020, 8'h00, 1);

        // back-to-back writes with transfer held high
        transfer = 1; req_write = 1; req_addr = 9'h001; req_wdata = 8'h11;
        k = 0; setup_chk = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge pclk);
            if (setup_chk) begin
                check("b2b_setup_penable", penable, 0);
                check("b2b_setup_psel1", psel1, 1);
                setup_chk = 0;
            end
            if (req_ready) begin
                acc[k] = cyc;
                ref_mem[0][k + 1] = req_wdata;
                k++;
                setup_chk = 1;
                @(posedge pclk);
                #1;
                if (k < 3) begin
                    req_addr = 9'(k + 1);
                    req_wdata = 8'(8'h11 * (k + 1));
                end else transfer = 0;
            end
        end
        check("b2b_count", k, 3);
        check("b2b_gap1", acc[1] - acc[0], 4);
        check("b2b_gap2", acc[2] - acc[1], 4);
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        check("b2b_last_rsp", {rsp_valid, rsp_err}, 2'b10);
        @(negedge pclk);
        xfer(0, 9'h002, 8'h00, 0);
        xfer(0, 9'h003, 8'h00, 0);

        for (int i = 0; i < 40; i++)
            xfer(1'($urandom), {1'($urandom), 5'd0, 3'($urandom_range(0, 7))}, 8'($urandom),
                 $urandom_range(0, 7) == 0);

        // reset in the middle of ACCESS
        transfer = 1; req_write = 0; req_addr = 9'h0AB;
        guard = 0;
        @(negedge pclk);
        while (!req_ready && guard < 20) begin
            guard++;
            @(negedge pclk);
        end
        @(posedge pclk);
        #1;
        transfer = 0;
        guard = 0;
        @(negedge pclk);
        while (!penable && guard < 20) begin
            guard++;
            @(negedge pclk);
        end
        check("mid_in_access", penable, 1);
        #2 preset = 0;
        #1 bus_zero("mid_reset");
        repeat (2) begin
            @(negedge pclk);
            check("mid_no_rsp", rsp_valid, 0);
        end
        preset = 1;
        ref_reset();
        @(negedge pclk);
        check("mid_ready", req_ready, 1);
        check("mid_no_rsp_after", rsp_valid, 0);
        xfer(0, 9'h0AB, 8'h00, 0);
        xfer(1, 9'h1AB, 8'h5E, 0);
        xfer(0, 9'h1AB, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/apb_master.md
# apb_master

APB requester that sits directly upstream of the 8-bit memory slaves on the peripheral bus. It accepts single read/write commands from a simple request port and decodes the target slave from the top request-address bit. It runs the APB SETUP/ACCESS sequence and waits for the selected slave's `pready`. It then returns read data, or a timeout error, on a one-cycle response strobe.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of ACCESS cycles before a transfer is aborted. Legal range is ≥2.

Ports:
- `pclk` in 1: bus clock. All state changes on its rising edge.
- `preset` in 1: reset, asynchronous, active-low.
- `transfer` in 1: request valid.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 9: bit 8 selects the slave (0 = slave 1, 1 = slave 2). Bits 7:0 are the slave address.
- `req_wdata` in 8: write data.
- `req_ready` out 1: request accepted when `transfer && req_ready` at a rising edge.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out 8: read data; 0 for writes and timeouts.
- `rsp_err` out 1: 1 if the transfer timed out.
- `psel1`, `psel2` out 1: slave selects, one-hot or both 0.
- `penable` out 1: ACCESS phase indicator.
- `pwrite` out 1: APB direction.
- `paddr` out 8: APB address.
- `pwdata` out 8: APB write data.
- `pready1`, `pready2` in 1: slave ready inputs.
- `prdata1`, `prdata2` in 8: slave read data.

## Operation
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - `req_ready`=1; all `psel*` and `penable` are 0.
  - On accept, register `req_write`, `req_addr`, `req_wdata` and go to SETUP.
- SETUP (exactly 1 cycle):
  - Selected `psel` = 1, `penable` = 0.
  - `paddr`, `pwrite`, `pwdata` driven from the registered request.
  - Always go to ACCESS.
- ACCESS:
  - Same outputs as SETUP, plus `penable` = 1.
  - Only the selected slave's `pready`/`prdata` are observed; the other slave's are ignored.
  - Selected `pready` = 1 at an edge: complete OK. Capture `rsp_rdata` = selected `prdata` for a read, 0 for a write. `rsp_err` = 0. Go to IDLE.
  - Timeout: a counter is cleared on entry to ACCESS and increments each ACCESS cycle. If `pready` is still 0 at the edge where the counter equals `TIMEOUT`-1, complete with `rsp_err` = 1 and `rsp_rdata` = 0. Go to IDLE.
  - `pready` is ignored in IDLE and SETUP.
- `paddr`, `pwrite`, `pwdata` hold their last values in IDLE; there is no change without a new request.
- `transfer` while `req_ready` = 0 is ignored; the requester must hold it.
- `req_ready` is low from the accept edge until the cycle after the completion edge. There is no accept in the same edge as completion.

## Timing
- Reset (asynchronous assert, immediate):
  - State goes to IDLE.
  - `psel1`, `psel2`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0.
  - `req_ready` = 0 while `preset` is low, and 1 from the first cycle after deassertion.
- Reset mid-transfer: the transfer is discarded, no `rsp_valid` is issued, and bus signals drop immediately.
- Latency with the registered-ready slaves (accept at edge E0):
  - SETUP occupies E0–E1; ACCESS starts at E1.
  - The slave raises `pready` at E2; the master completes at E3.
  - `rsp_valid` is high E3–E4; next accept is possible at E4.
- Back-to-back requests therefore run one transfer per 4 cycles. The slave's `pready` falls because `penable` = 0 in the next SETUP.
- Timeout path: ACCESS lasts exactly `TIMEOUT` cycles; `rsp_valid` follows at the completion edge.
- `rsp_valid` is a single-cycle pulse; `rsp_rdata`/`rsp_err` hold until the next completion.

## Test plan
- Write, then read back on slave 2:
  - Stimulus: write addr 0x1A5, data 0x3C; then read 0x1A5.
  - Response: `psel2` only, `psel1` stays 0. Write response `rsp_err` = 0, `rsp_rdata` = 0. Read returns 0x3C. `rsp_valid` appears 3 cycles after each accept.
- Slave 1 isolation: write 0x010 = 0x77 and read 0x010 → 0x77. Then read 0x110 on slave 2 → slave-2 memory value, not 0x77.
- Timeout:
  - Stimulus: tie `pready1` low, `TIMEOUT` = 4, read 0x020.
  - Response: `penable` high for exactly 4 cycles, then `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0; `req_ready` returns next cycle.
- Back-to-back: hold `transfer` high for 3 writes (0x001, 0x002, 0x003). Each is accepted 4 cycles apart, and `psel` drops to SETUP (`penable` = 0) between them.
- Busy request: change `req_addr` during ACCESS → the bus address is unchanged and the new value is taken only at the next `req_ready` edge.
- Reset mid-ACCESS: assert `preset` low during ACCESS → all bus outputs are 0 immediately and no `rsp_valid`. After release, a new read completes normally.
